ddr_clkgen: RTL and testbench
=============================

Name: ddr_clkgen

Overview:
- Programmable output-clock generator that produces the 2-bit DDR half-cycle sample stream consumed by the SB_IO-based DDR output-clock driver (oclkddr).
- Output clock half-period is set in units of i_clk half-cycles, so both odd and even divisors are exact. Divisor changes and start/stop are glitch-free: no runt high or low phases.
- Sits between the control/register logic and the DDR clock pin, and supplies edge strobes to data-launch logic in the same domain.

Parameters:
- LGDIV, 8, width of the divisor.
- DEFAULT_DIV, 4, divisor loaded at reset; must be nonzero.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_en  input  1  run request; low parks the clock low.
- i_div_stb  input  1  load-request strobe for i_div.
- i_div  input  LGDIV  requested half-period, in i_clk half-cycles (0 is treated as 1).
- o_ddr  output  2  [1] = first half-cycle sample, [0] = second half-cycle sample.
- o_ckstb  output  1  a 0->1 output transition occurs at the start of or within this cycle's o_ddr.
- o_cknstb  output  1  a 1->0 output transition occurs at the start of or within this cycle's o_ddr.
- o_busy  output  1  divisor change pending.
- o_active  output  1  clock running (not parked).

Behaviour:
- Reset: o_ddr=2'b00, o_ckstb=0, o_cknstb=0, o_busy=0, o_active=0; active divisor D=DEFAULT_DIV; level=0; count=D; state PARKED.
- All outputs are registered. An input sampled at edge n affects o_ddr no earlier than the cycle after edge n.
- Half-step rule, applied twice per cycle (first for o_ddr[1], then o_ddr[0]):
  - emit the current level;
  - count <= count-1;
  - if the new count is 0: toggle level, reload count=D.
- Resulting patterns (starting a high phase):
  - D=1 -> 10 every cycle;
  - D=2 -> 11,00;
  - D=3 -> 11,10,00 repeating.
- States:
  - PARKED: o_ddr=00, level=0, o_active=0. When i_en=1, go to RUN with level=1, count=D; the first o_ddr of RUN begins high.
  - RUN: half-step rule applies. If i_en=0, go to STOPPING.
  - STOPPING: keep running until the next 1->0 transition. The remainder of that cycle emits 0, then enter PARKED. A low phase in progress is truncated only after a complete high phase. If i_en returns to 1 while STOPPING, go back to RUN with no disturbance.
- Edge strobes:
  - Transitions are judged across the 3-sample window {previous o_ddr[0], o_ddr[1], o_ddr[0]}.
  - Previous o_ddr[0] is taken as 0 after reset or PARKED.
- Divisor change:
  - i_div_stb latches max(i_div,1) into a pending register and sets o_busy.
  - A later strobe overwrites the pending value (last wins).
  - The pending value is applied to D only at a 0->1 level reload, so the new rising phase and every later phase use it. It is never applied mid-phase.
  - In PARKED, the pending value applies on the next cycle.
  - o_busy clears in the cycle after the application.
  - A strobe coinciding with an application cycle remains pending for the next boundary.
- Width: count is LGDIV bits and never underflows, because the reload happens at 0.
- Asynchronous reset mid-operation: immediate return to reset values, regardless of state.

Decomposition:
- Shared package ddr_clk_pkg holds:
  - the LGDIV default;
  - the state encoding (PARKED, RUN, STOPPING);
  - the DDR bit-order constants (first half = bit 1).
- No sub-module is warranted. The half-step rule is a local function invoked twice per cycle.
- Top-level integration instantiates ddr_clkgen feeding oclkddr i_ddr.

Test Plan:
- Reset with DEFAULT_DIV=4, i_en=1 at cycle 2 -> o_ddr 00 until cycle 3, then 11,11,00,00 repeating. o_ckstb on cycles 3, 7, 11; o_cknstb on cycles 5, 9.
- Load D=3 while parked, then enable -> 11,10,00 repeating. o_ckstb every 3rd cycle; o_cknstb on the 10 cycle.
- Load D=1 -> 10 every cycle; o_ckstb=1 and o_cknstb=1 every cycle.
- Running at D=4, strobe i_div=2 in the middle of a high phase -> current high/low complete at 4, then 11,00. o_busy high from the cycle after the strobe until the cycle after the boundary.
- Running at D=3, drop i_en during the 11 cycle -> 10 completes the high phase, then 00 forever, o_active=0. Re-raise i_en -> next o_ddr=11.
- i_div=0 strobe -> behaves as D=1. Back-to-back strobes 5 then 2 in a high phase -> only 2 is applied at the boundary. Reset asserted mid-RUN -> o_ddr=00 immediately.

Source files
------------

// File: rtl/ddr_clk_pkg.sv
// Shared definitions for the DDR output-clock generator: divisor width default,
// controller state encoding and the half-cycle bit order of the DDR sample pair.
package ddr_clk_pkg;

    localparam int DDR_LGDIV_DEFAULT = 8;

    // First half of the i_clk cycle is driven from bit 1, second half from bit 0.
    localparam int DDR_FIRST  = 1;
    localparam int DDR_SECOND = 0;

    typedef enum logic [1:0] {
        ST_PARKED   = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } ddr_state_e;

endpackage

// File: rtl/ddr_clkgen.sv
// Programmable DDR output-clock generator: emits two half-cycle samples per i_clk
// cycle, with glitch-free divisor changes and start/stop, plus edge strobes.
module ddr_clkgen
    import ddr_clk_pkg::*;
#(
    parameter int LGDIV       = DDR_LGDIV_DEFAULT,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_div_stb,
    input  logic [LGDIV-1:0] i_div,
    output logic [1:0]       o_ddr,
    output logic             o_ckstb,
    output logic             o_cknstb,
    output logic             o_busy,
    output logic             o_active
);

    localparam logic [LGDIV-1:0] DEF_D = LGDIV'(DEFAULT_DIV);

    ddr_state_e       r_state;
    logic             r_level;
    logic [LGDIV-1:0] r_count;
    logic [LGDIV-1:0] r_div;
    logic [LGDIV-1:0] r_pend;
    logic             r_pvld;
    logic [1:0]       r_ddr;
    logic             r_ckstb;
    logic             r_cknstb;
    logic             r_busy;
    logic             r_active;

    ddr_state_e       w_state_nx;
    logic             w_level_nx;
    logic [LGDIV-1:0] w_count_nx;
    logic [LGDIV-1:0] w_div_nx;
    logic [LGDIV-1:0] w_pend_nx;
    logic             w_pvld_nx;
    logic [1:0]       w_ddr_nx;
    logic             w_ckstb_nx;
    logic             w_cknstb_nx;
    logic             w_busy_nx;
    logic             w_active_nx;
    logic             w_apply;

    logic             w_s1, w_l1, w_p1, w_f1, w_a1;
    logic             w_s2, w_l2, w_p2, w_f2, w_a2;
    logic [LGDIV-1:0] w_c1, w_d1, w_c2, w_d2;

    // One half-cycle of the output: emit the level, count down, and at zero toggle
    // and reload. A pending divisor is only taken on a low-to-high reload.
    function automatic void half_step(
        input  logic             lvl_i,
        input  logic [LGDIV-1:0] cnt_i,
        input  logic [LGDIV-1:0] div_i,
        input  logic             pvld_i,
        input  logic [LGDIV-1:0] pend_i,
        output logic             smp_o,
        output logic             lvl_o,
        output logic [LGDIV-1:0] cnt_o,
        output logic [LGDIV-1:0] div_o,
        output logic             pvld_o,
        output logic             fell_o,
        output logic             appl_o
    );
        logic [LGDIV-1:0] dec;
        dec    = cnt_i - LGDIV'(1);
        smp_o  = lvl_i;
        lvl_o  = lvl_i;
        cnt_o  = dec;
        div_o  = div_i;
        pvld_o = pvld_i;
        fell_o = 1'b0;
        appl_o = 1'b0;
        if (dec == '0) begin
            lvl_o  = ~lvl_i;
            fell_o = lvl_i;
            if (!lvl_i && pvld_i) begin
                div_o  = pend_i;
                pvld_o = 1'b0;
                appl_o = 1'b1;
            end
            cnt_o = div_o;
        end
    endfunction

    always_comb begin
        half_step(r_level, r_count, r_div, r_pvld, r_pend,
                  w_s1, w_l1, w_c1, w_d1, w_p1, w_f1, w_a1);
        half_step(w_l1, w_c1, w_d1, w_p1, r_pend,
                  w_s2, w_l2, w_c2, w_d2, w_p2, w_f2, w_a2);
    end

    always_comb begin
        w_state_nx  = r_state;
        w_level_nx  = r_level;
        w_count_nx  = r_count;
        w_div_nx    = r_div;
        w_pend_nx   = r_pend;
        w_pvld_nx   = r_pvld;
        w_ddr_nx    = 2'b00;
        w_apply     = 1'b0;
        w_active_nx = 1'b0;

        case (r_state)
            ST_PARKED: begin
                if (r_pvld) begin
                    w_div_nx  = r_pend;
                    w_pvld_nx = 1'b0;
                    w_apply   = 1'b1;
                end
                if (i_en) begin
                    w_state_nx = ST_RUN;
                    w_level_nx = 1'b1;
                    w_count_nx = w_div_nx;
                end
            end
            default: begin
                w_active_nx = 1'b1;
                // A stop request ends at the first high-to-low toggle; if that happens
                // in the first half, the second half is forced low and not evaluated.
                if (!i_en && w_f1) begin
                    w_ddr_nx[DDR_FIRST]  = w_s1;
                    w_ddr_nx[DDR_SECOND] = 1'b0;
                    w_state_nx = ST_PARKED;
                    w_level_nx = 1'b0;
                    w_count_nx = w_d1;
                    w_div_nx   = w_d1;
                    w_pvld_nx  = w_p1;
                    w_apply    = w_a1;
                end else begin
                    w_ddr_nx[DDR_FIRST]  = w_s1;
                    w_ddr_nx[DDR_SECOND] = w_s2;
                    w_level_nx = w_l2;
                    w_count_nx = w_c2;
                    w_div_nx   = w_d2;
                    w_pvld_nx  = w_p2;
                    w_apply    = w_a1 | w_a2;
                    if (!i_en && w_f2) begin
                        w_state_nx = ST_PARKED;
                        w_level_nx = 1'b0;
                    end else if (i_en) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        w_state_nx = ST_STOPPING;
                    end
                end
            end
        endcase

        // A strobe landing on an application cycle stays pending for the next boundary.
        if (i_div_stb) begin
            w_pend_nx = (i_div == '0) ? LGDIV'(1) : i_div;
            w_pvld_nx = 1'b1;
        end

        w_busy_nx   = w_pvld_nx | w_apply;
        w_ckstb_nx  = (~r_ddr[DDR_SECOND] &  w_ddr_nx[DDR_FIRST])
                    | (~w_ddr_nx[DDR_FIRST] & w_ddr_nx[DDR_SECOND]);
        w_cknstb_nx = ( r_ddr[DDR_SECOND] & ~w_ddr_nx[DDR_FIRST])
                    | ( w_ddr_nx[DDR_FIRST] & ~w_ddr_nx[DDR_SECOND]);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_PARKED;
            r_level  <= 1'b0;
            r_count  <= DEF_D;
            r_div    <= DEF_D;
            r_pend   <= DEF_D;
            r_pvld   <= 1'b0;
            r_ddr    <= 2'b00;
            r_ckstb  <= 1'b0;
            r_cknstb <= 1'b0;
            r_busy   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_level  <= w_level_nx;
            r_count  <= w_count_nx;
            r_div    <= w_div_nx;
            r_pend   <= w_pend_nx;
            r_pvld   <= w_pvld_nx;
            r_ddr    <= w_ddr_nx;
            r_ckstb  <= w_ckstb_nx;
            r_cknstb <= w_cknstb_nx;
            r_busy   <= w_busy_nx;
            r_active <= w_active_nx;
        end
    end

    assign o_ddr    = r_ddr;
    assign o_ckstb  = r_ckstb;
    assign o_cknstb = r_cknstb;
    assign o_busy   = r_busy;
    assign o_active = r_active;

endmodule

// File: tb/tb_ddr_clkgen.sv
// Scoreboard bench for ddr_clkgen: a phase-queue reference model predicts each
// cycle's outputs; a monitor compares them one cycle later.
module tb_ddr_clkgen;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_en;
    logic       i_div_stb;
    logic [7:0] i_div;
    logic [1:0] o_ddr;
    logic       o_ckstb;
    logic       o_cknstb;
    logic       o_busy;
    logic       o_active;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] exp_q[$];

    // Reference model: the current phase is a queue of remaining half-samples.
    bit m_run;
    bit m_lvl;
    int m_D;
    int m_pend;
    bit m_pv;
    bit m_prev;
    bit m_q[$];

    ddr_clkgen #(.LGDIV(8), .DEFAULT_DIV(4)) dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_en     (i_en),
        .i_div_stb(i_div_stb),
        .i_div    (i_div),
        .o_ddr    (o_ddr),
        .o_ckstb  (o_ckstb),
        .o_cknstb (o_cknstb),
        .o_busy   (o_busy),
        .o_active (o_active)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] got_vec();
        return {o_ddr, o_ckstb, o_cknstb, o_busy, o_active};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got ddr=%b ck=%b ckn=%b busy=%b act=%b, want ddr=%b ck=%b ckn=%b busy=%b act=%b",
                     name, $time, got[5:4], got[3], got[2], got[1], got[0],
                     exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_lvl  = 1'b0;
        m_D    = 4;
        m_pend = 4;
        m_pv   = 1'b0;
        m_prev = 1'b0;
        m_q.delete();
    endtask

    task automatic fill_phase(input bit lvl);
        m_lvl = lvl;
        m_q.delete();
        for (int k = 0; k < m_D; k++) m_q.push_back(lvl);
    endtask

    task automatic model_step(input bit en, input bit stb, input int div);
        bit s[2];
        bit applied;
        bit active;
        bit stopped;
        bit ck, ckn;
        s[0] = 1'b0;
        s[1] = 1'b0;
        applied = 1'b0;
        active  = 1'b0;
        stopped = 1'b0;
        if (!m_run) begin
            if (m_pv) begin
                m_D = m_pend;
                m_pv = 1'b0;
                applied = 1'b1;
            end
            if (en) begin
                m_run = 1'b1;
                fill_phase(1'b1);
            end
        end else begin
            active = 1'b1;
            for (int slot = 0; slot < 2; slot++) begin
                if (!stopped) begin
                    s[slot] = m_q.pop_front();
                    if (m_q.size() == 0) begin
                        if (m_lvl) begin
                            if (!en) stopped = 1'b1;
                            fill_phase(1'b0);
                        end else begin
                            if (m_pv) begin
                                m_D = m_pend;
                                m_pv = 1'b0;
                                applied = 1'b1;
                            end
                            fill_phase(1'b1);
                        end
                    end
                end
            end
            if (stopped) begin
                m_run = 1'b0;
                m_q.delete();
            end
        end
        if (stb) begin
            m_pend = (div == 0) ? 1 : div;
            m_pv = 1'b1;
        end
        ck  = (!m_prev && s[0]) || (!s[0] && s[1]);
        ckn = (m_prev && !s[0]) || (s[0] && !s[1]);
        m_prev = s[1];
        exp_q.push_back({s[0], s[1], ck, ckn, (m_pv || applied), active});
    endtask

    task automatic step(input bit en, input bit stb, input logic [7:0] div);
        @(posedge clk);
        #2;
        i_reset   = 1'b0;
        i_en      = en;
        i_div_stb = stb;
        i_div     = div;
        model_step(en, stb, int'(div));
    endtask

    task automatic run(input bit en, input int n);
        for (int k = 0; k < n; k++) step(en, 1'b0, 8'd0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        i_reset   = 1'b1;
        i_en      = 1'b0;
        i_div_stb = 1'b0;
        #1;
        check("async_reset", got_vec(), 6'b0);
        model_reset();
        exp_q.push_back(6'b0);
    endtask

    // Monitor: compare once per cycle, 1 time unit after the active edge.
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", got_vec(), e);
            end
        end
    end

    initial begin
        bit         en_r;
        bit         stb_r;
        logic [7:0] dv;

        i_reset   = 1'b1;
        i_en      = 1'b0;
        i_div_stb = 1'b0;
        i_div     = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        check("reset_state", got_vec(), 6'b0);

        // Default divisor start-up.
        run(1'b0, 2);
        run(1'b1, 14);
        run(1'b0, 8);
        // Load 3 while parked, then enable.
        step(1'b0, 1'b1, 8'd3);
        run(1'b0, 2);
        run(1'b1, 12);
        // Switch to 1 while running.
        step(1'b1, 1'b1, 8'd1);
        run(1'b1, 10);
        // Back to 4, then request 2 part-way into a high phase.
        step(1'b1, 1'b1, 8'd4);
        run(1'b1, 12);
        step(1'b1, 1'b1, 8'd2);
        run(1'b1, 12);
        // Divisor 3, drop enable mid high phase, re-enable.
        step(1'b1, 1'b1, 8'd3);
        run(1'b1, 10);
        run(1'b0, 8);
        run(1'b1, 6);
        // Zero divisor acts as 1.
        step(1'b1, 1'b1, 8'd0);
        run(1'b1, 8);
        // Back-to-back strobes: only the last survives.
        step(1'b1, 1'b1, 8'd4);
        run(1'b1, 9);
        step(1'b1, 1'b1, 8'd5);
        step(1'b1, 1'b1, 8'd2);
        run(1'b1, 12);
        mid_reset();
        run(1'b1, 10);

        en_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 6) en_r = ~en_r;
            stb_r = ($urandom_range(0, 99) < 6);
            dv = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                              : 8'($urandom_range(0, 5));
            if (n == 1500 || n == 2400) mid_reset();
            else step(en_r, stb_r, dv);
        end

        @(posedge clk);
        #2;
        i_en = 1'b0;
        i_div_stb = 1'b0;
        @(posedge clk);
        #3;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
